dec_nxm_seq: RTL

Parametrised successor to the team's 2-to-4 enable decoder. Decodes an N-bit select into a 2^N-bit one-hot output, but registers the output and adds two timed modes.
- Pulse: a one-hot output held for a programmable number of cycles.
- Scan: a rotating one-hot walk with a programmable dwell time.

Used as a chip-select, strobe and row-scan generator in the same designs that use the plain decoder.

---
 rtl/dec_nxm_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dec_nxm_seq.sv
// +----------------------------------------------------------------------------+
// | dec_nxm_seq: registered N-to-2^N decoder with timed pulse and scan modes.  |
// | Optional: DEC_STICKY_ERR_EN adds sticky err output. Rev 1.0                |
// +----------------------------------------------------------------------------+
`default_nettype none

module dec_nxm_seq #(
  parameter int N     = 2,
  parameter int DIV_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [N-1:0]      a,
  input  logic              load,
  input  logic [DIV_W-1:0]  period,
  output logic [(1<<N)-1:0] d,
  output logic              busy
`ifdef DEC_STICKY_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int OUT_W = 1 << N;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_PULSE  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    SCAN  = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [OUT_W-1:0]   d_nx;
  logic [DIV_W-1:0]   cnt, cnt_nx;
  logic [DIV_W-1:0]   period_q, period_nx;
  logic [N-1:0]       idx, idx_nx;

  function automatic logic [OUT_W-1:0] onehot(input logic [N-1:0] i);
    logic [OUT_W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      d        <= '0;
      cnt      <= '0;
      period_q <= '0;
      idx      <= '0;
    end else begin
      state    <= state_nx;
      d        <= d_nx;
      cnt      <= cnt_nx;
      period_q <= period_nx;
      idx      <= idx_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    d_nx      = d;
    cnt_nx    = cnt;
    period_nx = period_q;
    idx_nx    = idx;

    if (!en) begin
      state_nx = IDLE;
      d_nx     = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          // Outside direct mode the idle output is all-zero until a load.
          d_nx   = '0;
          cnt_nx = '0;
          case (mode)
            MODE_DIRECT: d_nx = onehot(a);
            MODE_PULSE: begin
              if (load) begin
                state_nx  = PULSE;
                d_nx      = onehot(a);
                period_nx = period;
              end
            end
            MODE_SCAN: begin
              if (load) begin
                state_nx  = SCAN;
                idx_nx    = a;
                d_nx      = onehot(a);
                period_nx = period;
              end
            end
            default: ;
          endcase
        end
        PULSE: begin
          if (cnt == period_q) begin
            state_nx = IDLE;
            d_nx     = '0;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        SCAN: begin
          if (load && (mode != MODE_SCAN)) begin
            state_nx = IDLE;
            d_nx     = '0;
            cnt_nx   = '0;
          end else if (cnt == period_q) begin
            idx_nx = idx + 1'b1;
            d_nx   = onehot(idx_nx);
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          d_nx     = '0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef DEC_STICKY_ERR_EN
  logic err_set;
  assign err_set = en && load && ((mode == 2'b11) || (state == PULSE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= err | err_set;
    end
  end
`endif

endmodule

`default_nettype wire
